writeback_queue: RTL and testbench

- Parametrised register-writeback stage for the EV22 datapath.
- Takes one writeback request per cycle from execute/memory and resolves the destination register. Memory reads are redirected to the working register. Null-destination writes and stores are dropped.
- Surviving writes go into a DEPTH-entry FIFO that drains into the register-file write port under a valid/ready handshake.
- A forwarding lookup returns the youngest pending value for any register, so the decode stage can bypass the queue.

---
 rtl/ev22_wb_pkg.sv | 48 ++++
 rtl/writeback_queue_fifo.sv | 47 ++++
 rtl/writeback_queue.sv | 121 ++++++++++++
 tb/tb_writeback_queue.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ev22_wb_pkg.sv
// EV22 writeback queue shared types.
// Request record and the destination classification helper.
package ev22_wb_pkg;

  localparam int WB_W_REG_IDX = 34;
  localparam int WB_NULL_IDX  = 35;

  // Widest word/select any instance may use.
  localparam int WB_MAX_DATA_W = 64;
  localparam int WB_MAX_SEL_W  = 16;

  typedef struct packed {
    logic [WB_MAX_SEL_W-1:0]  sel;
    logic [WB_MAX_DATA_W-1:0] data;
  } wb_req_t;

  typedef struct packed {
    logic    drop;
    wb_req_t req;
  } wb_cls_t;

  // Memory reads win over the null/store drop rule.
  function automatic wb_cls_t wb_classify(
    input logic                     mem_read,
    input logic                     mem_write,
    input logic [WB_MAX_SEL_W-1:0]  alu_sel,
    input logic [WB_MAX_DATA_W-1:0] alu_data,
    input logic [WB_MAX_DATA_W-1:0] mem_data,
    input logic [WB_MAX_SEL_W-1:0]  w_reg,
    input logic [WB_MAX_SEL_W-1:0]  null_idx
  );
    wb_cls_t c;
    c.drop     = 1'b0;
    c.req.sel  = alu_sel;
    c.req.data = alu_data;
    priority case (1'b1)
      mem_read: begin
        c.req.sel  = w_reg;
        c.req.data = mem_data;
      end
      mem_write,
      (alu_sel == null_idx): c.drop = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/writeback_queue_fifo.sv
// Generic FIFO with counted occupancy.
// Storage and read pointer are exposed for the forwarding scan.
module wb_fifo #(
  parameter int W     = 22,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [W-1:0]              wdata,
  output logic [W-1:0]              head,
  output logic [CNT_W-1:0]          count,
  output logic [PTR_W-1:0]          rd_ptr,
  output logic [DEPTH-1:0][W-1:0]   store
);

  logic [PTR_W-1:0] wr_ptr;

  assign head = store[rd_ptr];

  // Storage, pointers and occupancy; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      store  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        store[wr_ptr] <= wdata;
        wr_ptr        <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// EV22 register writeback queue.
// Classifies requests, queues survivors, forwards youngest value.
module writeback_queue
  import ev22_wb_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int SEL_W     = 6,
  parameter int W_REG_IDX = WB_W_REG_IDX,
  parameter int NULL_IDX  = WB_NULL_IDX,
  parameter int DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic [SEL_W-1:0]         alu_sel,
  input  logic [DATA_W-1:0]        mem_data,
  input  logic                     mem_read,
  input  logic                     mem_write,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  input  logic [SEL_W-1:0]         fwd_sel,
  output logic                     fwd_hit,
  output logic [DATA_W-1:0]        fwd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int W     = SEL_W + DATA_W;

  logic [WB_MAX_SEL_W-1:0]  sel_ext;
  logic [WB_MAX_DATA_W-1:0] alu_ext;
  logic [WB_MAX_DATA_W-1:0] mem_ext;
  wb_cls_t                  cls;
  logic                     unused_cls;

  logic                     accept;
  logic                     push;
  logic                     pop;
  logic [W-1:0]             wdata;
  logic [W-1:0]             head;
  logic [PTR_W-1:0]         rd_ptr;
  logic [DEPTH-1:0][W-1:0]  store;
  logic [PTR_W-1:0]         idx;

  // Widen the request to package width and classify it.
  always_comb begin
    sel_ext = '0;
    alu_ext = '0;
    mem_ext = '0;
    sel_ext[SEL_W-1:0]  = alu_sel;
    alu_ext[DATA_W-1:0] = alu_data;
    mem_ext[DATA_W-1:0] = mem_data;
    cls = wb_classify(mem_read, mem_write, sel_ext,
                      alu_ext, mem_ext,
                      WB_MAX_SEL_W'(W_REG_IDX),
                      WB_MAX_SEL_W'(NULL_IDX));
  end

  assign unused_cls = ^cls;
  assign wdata      = {cls.req.sel[SEL_W-1:0],
                       cls.req.data[DATA_W-1:0]};

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign in_ready  = rst | (count < CNT_W'(DEPTH)) | out_ready;
  assign accept    = in_valid & in_ready;
  assign push      = accept & ~cls.drop;

  assign out_sel  = head[W-1:DATA_W];
  assign out_data = head[DATA_W-1:0];

  wb_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .wdata  (wdata),
    .head   (head),
    .count  (count),
    .rd_ptr (rd_ptr),
    .store  (store)
  );

  // Scan oldest to youngest so the last match is the youngest.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) &&
          (store[idx][W-1:DATA_W] == fwd_sel)) begin
        fwd_hit  = 1'b1;
        fwd_data = store[idx][DATA_W-1:0];
      end
    end
    if (fwd_sel == SEL_W'(NULL_IDX)) begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
    end
  end

  // Saturating count of accepted-but-dropped requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (accept && cls.drop && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed steps then random traffic.
// Expected values come from a queue-based reference model.
module tb_writeback_queue;

  localparam int DW    = 16;
  localparam int SW    = 6;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] alu_data;
  logic [SW-1:0] alu_sel;
  logic [DW-1:0] mem_data;
  logic          mem_read;
  logic          mem_write;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [SW-1:0] out_sel;
  logic [SW-1:0] fwd_sel;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic [2:0]    count;
  logic [15:0]   drop_cnt;

  always #5 clk = ~clk;

  writeback_queue #(
    .DATA_W    (DW),
    .SEL_W     (SW),
    .W_REG_IDX (34),
    .NULL_IDX  (35),
    .DEPTH     (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_data  (alu_data),
    .alu_sel   (alu_sel),
    .mem_data  (mem_data),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .fwd_sel   (fwd_sel),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
    .count     (count),
    .drop_cnt  (drop_cnt)
  );

  typedef struct {
    logic [SW-1:0] sel;
    logic [DW-1:0] data;
  } ent_t;

  ent_t q[$];
  int   mdrop  = 0;
  int   passes = 0;
  int   total  = 0;
  int   drain_exp[4] = '{2, 3, 4, 9};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic void mfwd(input logic [SW-1:0] s,
                               output logic h,
                               output logic [DW-1:0] d);
    h = 1'b0;
    d = '0;
    if (s != 6'd35) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].sel == s) begin
          h = 1'b1;
          d = q[i].data;
          break;
        end
      end
    end
  endfunction

  task automatic step(input logic r, input logic iv,
                      input logic mr, input logic mw,
                      input logic ordy,
                      input logic [SW-1:0] asel,
                      input logic [SW-1:0] fs,
                      input logic [DW-1:0] ad,
                      input logic [DW-1:0] md);
    logic          h;
    logic [DW-1:0] d;
    logic          rdy;
    ent_t          e;
    @(negedge clk);
    rst       = r;
    in_valid  = iv;
    mem_read  = mr;
    mem_write = mw;
    out_ready = ordy;
    alu_sel   = asel;
    fwd_sel   = fs;
    alu_data  = ad;
    mem_data  = md;
    #1;
    rdy = r || (q.size() < DEPTH) || ordy;
    chk("in_ready", in_ready, rdy);
    chk("out_valid", out_valid, q.size() != 0);
    chk("count", count, q.size());
    chk("drop_cnt", drop_cnt, mdrop);
    if (q.size() != 0) begin
      chk("out_sel", out_sel, q[0].sel);
      chk("out_data", out_data, q[0].data);
    end
    mfwd(fs, h, d);
    chk("fwd_hit", fwd_hit, h);
    chk("fwd_data", fwd_data, d);
    @(posedge clk);
    if (r) begin
      q.delete();
      mdrop = 0;
    end else begin
      if (q.size() != 0 && ordy) void'(q.pop_front());
      if (iv && rdy) begin
        if (mr) begin
          e.sel  = 6'd34;
          e.data = md;
          q.push_back(e);
        end else if (mw || asel == 6'd35) begin
          if (mdrop < 65535) mdrop++;
        end else begin
          e.sel  = asel;
          e.data = ad;
          q.push_back(e);
        end
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    out_ready = 1'b0;
    alu_sel   = '0;
    fwd_sel   = '0;
    alu_data  = '0;
    mem_data  = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_out_sel", out_sel, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_fwd_hit", fwd_hit, 0);
    chk("rst_fwd_data", fwd_data, 0);
    chk("rst_in_ready", in_ready, 1);

    // ALU write
    step(0, 1, 0, 0, 0, 6'd5, 6'd0, 16'h1234, 16'h0);
    #2;
    chk("t1_valid", out_valid, 1);
    chk("t1_sel", out_sel, 5);
    chk("t1_data", out_data, 16'h1234);
    chk("t1_count", count, 1);

    // memory read redirected to working register
    step(0, 1, 1, 0, 0, 6'd35, 6'd0, 16'h0, 16'hBEEF);
    #2;
    chk("t2_count", count, 2);
    chk("t2_drop", drop_cnt, 0);
    step(0, 0, 0, 0, 1, 6'd0, 6'd0, 16'h0, 16'h0);
    #2;
    chk("t2_sel", out_sel, 34);
    chk("t2_data", out_data, 16'hBEEF);
    step(0, 0, 0, 0, 1, 6'd0, 6'd0, 16'h0, 16'h0);
    #2;
    chk("t2_empty", count, 0);

    // drops
    step(0, 1, 0, 0, 0, 6'd35, 6'd0, 16'h1, 16'h0);
    step(0, 1, 0, 1, 0, 6'd7, 6'd0, 16'h2, 16'h0);
    #2;
    chk("t3_count", count, 0);
    chk("t3_drop", drop_cnt, 2);

    // fill and stall
    for (int k = 1; k <= 4; k++)
      step(0, 1, 0, 0, 0, SW'(k), 6'd0, DW'(9 + k), 16'h0);
    #2;
    chk("t4_full", count, 4);
    chk("t4_ready", in_ready, 0);
    chk("t4_head", out_sel, 1);
    step(0, 1, 0, 0, 1, 6'd9, 6'd0, 16'd99, 16'h0);
    #2;
    chk("t4_count", count, 4);
    chk("t4_head2", out_sel, 2);
    for (int k = 0; k < 4; k++) begin
      chk("t4_drain", out_sel, drain_exp[k]);
      step(0, 0, 0, 0, 1, 6'd0, 6'd0, 16'h0, 16'h0);
      #2;
    end
    chk("t4_empty", count, 0);

    // forwarding
    step(0, 1, 0, 0, 0, 6'd3, 6'd0, 16'h000A, 16'h0);
    step(0, 1, 0, 0, 0, 6'd3, 6'd3, 16'h000B, 16'h0);
    #2;
    chk("t5_hit", fwd_hit, 1);
    chk("t5_data", fwd_data, 16'h000B);
    step(0, 0, 0, 0, 0, 6'd0, 6'd4, 16'h0, 16'h0);
    #2;
    chk("t5_miss", fwd_hit, 0);
    chk("t5_miss_data", fwd_data, 0);

    // reset mid-operation
    step(0, 1, 0, 0, 0, 6'd6, 6'd0, 16'h0066, 16'h0);
    for (int k = 0; k < 3; k++)
      step(0, 1, 0, 0, 0, 6'd35, 6'd0, 16'h0, 16'h0);
    #2;
    chk("t6_pre_count", count, 3);
    chk("t6_pre_drop", drop_cnt, 5);
    step(1, 1, 0, 0, 0, 6'd5, 6'd0, 16'h5555, 16'h0);
    #2;
    chk("t6_count", count, 0);
    chk("t6_valid", out_valid, 0);
    chk("t6_drop", drop_cnt, 0);
    step(0, 0, 0, 0, 0, 6'd0, 6'd0, 16'h0, 16'h0);
    #2;
    chk("t6_ready", in_ready, 1);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic [SW-1:0] as;
      logic [SW-1:0] fs;
      as = ($urandom_range(0, 7) == 0) ? 6'd35 : SW'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0:       fs = 6'd35;
        1:       fs = 6'd34;
        default: fs = SW'($urandom_range(0, 7));
      endcase
      step($urandom_range(0, 59) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 1) == 1,
           as, fs, DW'($urandom), DW'($urandom));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
